// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared types and line levels for the UART TX framing path.
// Imported by the framing controller, its serializer and its interface users.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_e;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_tx_frame_ctrl_if.sv
// uart_tx_frame_ctrl_if: byte-side and line-side signals of the TX framer.
// master drives the byte request and parity bit; slave is the framer.
interface uart_tx_frame_ctrl_if #(
   parameter int DATA_WIDTH = 8
);

   logic [DATA_WIDTH-1:0] p_data;
   logic                  data_valid;
   logic                  par_en;
   logic                  par_bit;
   logic                  par_load;
   logic                  tx_out;
   logic                  busy;

   modport master (
      output p_data,
      output data_valid,
      output par_en,
      output par_bit,
      input  par_load,
      input  tx_out,
      input  busy
   );

   modport slave (
      input  p_data,
      input  data_valid,
      input  par_en,
      input  par_bit,
      output par_load,
      output tx_out,
      output busy
   );

endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: data shift register and bit counter for one frame.
// ser_data is the LSB the register holds after the coming edge.
module uart_tx_serializer
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  ser_en,
   input  logic [DATA_WIDTH-1:0] data,
   output logic                  ser_data,
   output logic                  ser_done
);

   localparam int CW = (clog2(DATA_WIDTH) < 1) ? 1 : clog2(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]         cnt_q, cnt_d;

   assign ser_done = (cnt_q == CW'(DATA_WIDTH - 1));
   assign ser_data = shift_d[0];

   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (load) begin
         shift_d = data;
         cnt_d   = '0;
      end else if (ser_en) begin
         shift_d = shift_q >> 1;
         cnt_d   = ser_done ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// uart_tx_frame_ctrl: UART TX framing FSM and registered line driver.
// Sends start, data LSB first, optional parity and stop bits, one per clk.
module uart_tx_frame_ctrl
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int STOP_BITS  = 1
) (
   input logic                 clk,
   input logic                 rst,
   uart_tx_frame_ctrl_if.slave bus
);

   state_e state_q, state_d;
   logic   tx_q, tx_d;
   logic   busy_q, busy_d;
   logic   par_en_q, par_en_d;
   logic   stop_cnt_q, stop_cnt_d;
   logic   accept;
   logic   stop_last;
   logic   ser_data;
   logic   ser_done;

   assign accept    = (state_q == IDLE) && bus.data_valid;
   assign stop_last = (int'(stop_cnt_q) == STOP_BITS - 1);

   assign bus.par_load = accept;
   assign bus.tx_out   = tx_q;
   assign bus.busy     = busy_q;

   uart_tx_serializer #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_ser (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .ser_en  (state_q == DATA),
      .data    (bus.p_data),
      .ser_data(ser_data),
      .ser_done(ser_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         tx_q       <= IDLE_LEVEL;
         busy_q     <= 1'b0;
         par_en_q   <= 1'b0;
         stop_cnt_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         par_en_q   <= par_en_d;
         stop_cnt_q <= stop_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      par_en_d   = accept ? bus.par_en : par_en_q;
      stop_cnt_d = (state_q == STOP) ? ~stop_cnt_q : 1'b0;
      unique case (state_q)
         IDLE:    if (bus.data_valid) state_d = START;
         START:   state_d = DATA;
         DATA:    if (ser_done) state_d = par_en_q ? PARITY : STOP;
         PARITY:  state_d = STOP;
         STOP:    if (stop_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Line level follows the state being entered, so tx_out is a clean flop.
   always_comb begin
      tx_d   = IDLE_LEVEL;
      busy_d = 1'b1;
      unique case (state_d)
         IDLE: begin
            tx_d   = IDLE_LEVEL;
            busy_d = 1'b0;
         end
         START:   tx_d = START_LEVEL;
         DATA:    tx_d = ser_data;
         PARITY:  tx_d = bus.par_bit;
         STOP:    tx_d = STOP_LEVEL;
         default: begin
            tx_d   = IDLE_LEVEL;
            busy_d = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// tb_uart_tx_frame_ctrl: directed and random frames against a frame model.
// Two instances run in lockstep, one with one stop bit and one with two.
module tb_uart_tx_frame_ctrl;

   localparam int DW = 8;

   typedef logic bitq_t[$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   uart_tx_frame_ctrl_if #(.DATA_WIDTH(DW)) bus1 ();
   uart_tx_frame_ctrl_if #(.DATA_WIDTH(DW)) bus2 ();

   uart_tx_frame_ctrl #(
      .DATA_WIDTH(DW),
      .STOP_BITS (1)
   ) dut1 (
      .clk(clk),
      .rst(rst),
      .bus(bus1.slave)
   );

   uart_tx_frame_ctrl #(
      .DATA_WIDTH(DW),
      .STOP_BITS (2)
   ) dut2 (
      .clk(clk),
      .rst(rst),
      .bus(bus2.slave)
   );

   always #5 clk = ~clk;

   // Upstream even-parity calculator, loaded by par_load.
   always @(posedge clk) begin
      if (rst) bus1.par_bit <= 1'b0;
      else if (bus1.par_load) bus1.par_bit <= ^bus1.p_data;
   end

   always @(posedge clk) begin
      if (rst) bus2.par_bit <= 1'b0;
      else if (bus2.par_load) bus2.par_bit <= ^bus2.p_data;
   end

   function automatic bitq_t frame(input logic [DW-1:0] d,
                                   input logic pe, input int sb);
      bitq_t q;
      q.push_back(1'b0);
      for (int i = 0; i < DW; i++) q.push_back(d[i]);
      if (pe) q.push_back(^d);
      for (int i = 0; i < sb; i++) q.push_back(1'b1);
      return q;
   endfunction

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [DW-1:0] d,
                        input logic pe);
      bus1.data_valid = v;
      bus1.p_data     = d;
      bus1.par_en     = pe;
      bus2.data_valid = v;
      bus2.p_data     = d;
      bus2.par_en     = pe;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " tx1"}, bus1.tx_out, 1'b1);
      chk({tag, " busy1"}, bus1.busy, 1'b0);
      chk({tag, " pl1"}, bus1.par_load, 1'b0);
      chk({tag, " tx2"}, bus2.tx_out, 1'b1);
      chk({tag, " busy2"}, bus2.busy, 1'b0);
      chk({tag, " pl2"}, bus2.par_load, 1'b0);
   endtask

   task automatic send(input string tag, input logic [DW-1:0] d,
                       input logic pe, input bit noise,
                       input logic [DW-1:0] nd);
      bitq_t e1, e2;
      int    n;
      e1 = frame(d, pe, 1);
      e2 = frame(d, pe, 2);
      n  = e2.size();
      @(negedge clk);
      drive(1'b1, d, pe);
      #1;
      chk({tag, " accept pl1"}, bus1.par_load, 1'b1);
      chk({tag, " accept pl2"}, bus2.par_load, 1'b1);
      @(negedge clk);
      for (int k = 0; k <= n; k++) begin
         if (k == 0) drive(1'b0, DW'($urandom), 1'($urandom));
         if (noise && k == 3) drive(1'b1, nd, 1'($urandom));
         if (noise && k == 4) drive(1'b0, DW'($urandom), 1'($urandom));
         #1;
         chk($sformatf("%s k%0d tx1", tag, k), bus1.tx_out,
             (k < e1.size()) ? e1[k] : 1'b1);
         chk($sformatf("%s k%0d busy1", tag, k), bus1.busy,
             k < e1.size());
         chk($sformatf("%s k%0d pl1", tag, k), bus1.par_load, 1'b0);
         chk($sformatf("%s k%0d tx2", tag, k), bus2.tx_out,
             (k < n) ? e2[k] : 1'b1);
         chk($sformatf("%s k%0d busy2", tag, k), bus2.busy, k < n);
         chk($sformatf("%s k%0d pl2", tag, k), bus2.par_load, 1'b0);
         if (k < n) @(negedge clk);
      end
   endtask

   // Held data_valid: each instance repeats frame + one idle cycle.
   task automatic b2b(input logic [DW-1:0] d, input int frames);
      bitq_t e1, e2;
      int    l1, l2, m1, m2;
      e1 = frame(d, 1'b0, 1);
      e2 = frame(d, 1'b0, 2);
      l1 = e1.size();
      l2 = e2.size();
      @(negedge clk);
      drive(1'b1, d, 1'b0);
      #1;
      chk("b2b first pl1", bus1.par_load, 1'b1);
      chk("b2b first pl2", bus2.par_load, 1'b1);
      for (int k = 0; k < frames * (l2 + 1); k++) begin
         @(negedge clk);
         #1;
         m1 = k % (l1 + 1);
         m2 = k % (l2 + 1);
         chk($sformatf("b2b k%0d tx1", k), bus1.tx_out,
             (m1 < l1) ? e1[m1] : 1'b1);
         chk($sformatf("b2b k%0d busy1", k), bus1.busy, m1 < l1);
         chk($sformatf("b2b k%0d pl1", k), bus1.par_load, m1 == l1);
         chk($sformatf("b2b k%0d tx2", k), bus2.tx_out,
             (m2 < l2) ? e2[m2] : 1'b1);
         chk($sformatf("b2b k%0d busy2", k), bus2.busy, m2 < l2);
         chk($sformatf("b2b k%0d pl2", k), bus2.par_load, m2 == l2);
      end
      drive(1'b0, d, 1'b0);
      for (int i = 0; i < 40 && (bus1.busy || bus2.busy); i++) begin
         @(negedge clk);
         #1;
      end
      chk("b2b drain busy1", bus1.busy, 1'b0);
      chk("b2b drain busy2", bus2.busy, 1'b0);
   endtask

   initial begin
      drive(1'b0, '0, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      chk_idle("in reset");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         chk_idle($sformatf("idle%0d", i));
      end

      send("a5p", 8'hA5, 1'b1, 1'b0, 8'h00);
      send("3c", 8'h3C, 1'b0, 1'b0, 8'h00);
      send("0f ign", 8'h0F, 1'b0, 1'b1, 8'hFF);
      b2b(8'h55, 3);
      b2b(DW'($urandom), 2);

      // Reset during data bit 3 of 0xA5.
      @(negedge clk);
      drive(1'b1, 8'hA5, 1'b1);
      @(negedge clk);
      drive(1'b0, 8'h00, 1'b0);
      repeat (4) @(negedge clk);
      #1;
      chk("pre-rst bit3 tx1", bus1.tx_out, 1'b0);
      chk("pre-rst bit3 tx2", bus2.tx_out, 1'b0);
      rst = 1'b1;
      #1;
      chk_idle("async rst");
      @(negedge clk);
      #1;
      chk_idle("rst held");
      rst = 1'b0;
      send("81 post-rst", 8'h81, 1'b1, 1'b0, 8'h00);

      for (int r = 0; r < 6; r++) begin
         send($sformatf("rnd%0d", r), DW'($urandom), 1'($urandom),
              1'($urandom), DW'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
